// File: rtl/dds_pkg.sv
// Shared definitions for the DDS voice controller: command opcodes, parser states, default widths.
package dds_pkg;

  localparam int unsigned DdsTuneW = 16;
  localparam int unsigned DdsSelW  = 3;
  localparam int unsigned DdsDurW  = 8;

  typedef enum logic [1:0] {
    OpSetTune = 2'b00,
    OpSetSel  = 2'b01,
    OpSetDur  = 2'b10,
    OpCommit  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StHdr = 2'b00,
    StD1  = 2'b01,
    StD0  = 2'b10,
    StCmt = 2'b11
  } state_e;

endpackage

// File: rtl/dds_note_timer.sv
// Per-voice note-duration timer: reload on commit, count down on prescaler ticks, drop gate at expiry.
module dds_note_timer
  import dds_pkg::*;
#(
  parameter int unsigned DurW = DdsDurW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_i,
  input  logic            load_i,
  input  logic [DurW-1:0] load_val_i,
  output logic            gate_o
);

  logic [DurW-1:0] cnt_q, cnt_d;
  logic            gate_q, gate_d;

  always_comb begin
    cnt_d  = cnt_q;
    gate_d = gate_q;
    // Load beats a coincident tick; a zero count with gate high sustains indefinitely.
    if (load_i) begin
      cnt_d  = load_val_i;
      gate_d = 1'b1;
    end else if (tick_i && gate_q) begin
      if (cnt_q > DurW'(1)) begin
        cnt_d = cnt_q - DurW'(1);
      end else if (cnt_q == DurW'(1)) begin
        cnt_d  = '0;
        gate_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/dds_voice_ctrl.sv
// Byte-stream command parser with per-voice shadow registers, atomic commit to active registers,
// a free-running duration prescaler and one note timer per voice.
module dds_voice_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned NVOICE   = 2,
  parameter int unsigned TUNE_W   = DdsTuneW,
  parameter int unsigned SEL_W    = DdsSelW,
  parameter int unsigned DUR_W    = DdsDurW,
  parameter int unsigned PRESCALE = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     busy,
  output logic [NVOICE*TUNE_W-1:0] tune_o,
  output logic [NVOICE*SEL_W-1:0]  sel_o,
  output logic [NVOICE-1:0]        gate_o
);

  localparam int unsigned PreW = $clog2(PRESCALE);

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [3:0]                idx_q, idx_d;
  logic [7:0]                msb_q, msb_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic [TUNE_W-1:0]         shadow_tune_q [NVOICE];
  logic [TUNE_W-1:0]         shadow_tune_d [NVOICE];
  logic [SEL_W-1:0]          shadow_sel_q  [NVOICE];
  logic [SEL_W-1:0]          shadow_sel_d  [NVOICE];
  logic [DUR_W-1:0]          shadow_dur_q  [NVOICE];
  logic [DUR_W-1:0]          shadow_dur_d  [NVOICE];
  logic [NVOICE*TUNE_W-1:0]  tune_q, tune_d;
  logic [NVOICE*SEL_W-1:0]   sel_q, sel_d;
  logic [NVOICE-1:0]         load;
  logic [PreW-1:0]           pre_q, pre_d;
  logic                      tick;
  logic                      accept;
  logic [TUNE_W+15:0]        tune_ext;
  logic [SEL_W+7:0]          sel_ext;
  logic [DUR_W+7:0]          dur_ext;

  assign accept   = wr_valid && ready_q;
  assign tune_ext = {{TUNE_W{1'b0}}, msb_q, wr_data};
  assign sel_ext  = {{SEL_W{1'b0}}, wr_data};
  assign dur_ext  = {{DUR_W{1'b0}}, wr_data};

  assign tick  = (pre_q == PreW'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + PreW'(1);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    idx_d         = idx_q;
    msb_d         = msb_q;
    shadow_tune_d = shadow_tune_q;
    shadow_sel_d  = shadow_sel_q;
    shadow_dur_d  = shadow_dur_q;
    tune_d        = tune_q;
    sel_d         = sel_q;
    load          = '0;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          op_d  = op_e'(wr_data[7:6]);
          idx_d = wr_data[3:0];
          unique case (op_e'(wr_data[7:6]))
            OpSetTune: state_d = StD1;
            OpCommit:  state_d = StCmt;
            default:   state_d = StD0;
          endcase
        end
      end
      StD1: begin
        if (accept) begin
          msb_d   = wr_data;
          state_d = StD0;
        end
      end
      StD0: begin
        if (accept) begin
          state_d = StHdr;
          // Out-of-range voice indices match no voice, so the data is consumed silently.
          for (int unsigned i = 0; i < NVOICE; i++) begin
            if (idx_q == 4'(i)) begin
              unique case (op_q)
                OpSetTune: shadow_tune_d[i] = tune_ext[TUNE_W-1:0];
                OpSetSel:  shadow_sel_d[i]  = sel_ext[SEL_W-1:0];
                OpSetDur:  shadow_dur_d[i]  = dur_ext[DUR_W-1:0];
                default:   ;
              endcase
            end
          end
        end
      end
      StCmt: begin
        state_d = StHdr;
        for (int unsigned i = 0; i < NVOICE; i++) begin
          if (idx_q[i]) begin
            tune_d[i*TUNE_W +: TUNE_W] = shadow_tune_q[i];
            sel_d[i*SEL_W +: SEL_W]    = shadow_sel_q[i];
            load[i]                    = 1'b1;
          end
        end
      end
      default: state_d = StHdr;
    endcase
    ready_d = (state_d != StCmt);
    busy_d  = (state_d != StHdr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHdr;
      op_q    <= OpSetTune;
      idx_q   <= '0;
      msb_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      tune_q  <= '0;
      sel_q   <= '0;
      pre_q   <= '0;
      for (int unsigned i = 0; i < NVOICE; i++) begin
        shadow_tune_q[i] <= '0;
        shadow_sel_q[i]  <= '0;
        shadow_dur_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      msb_q         <= msb_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      tune_q        <= tune_d;
      sel_q         <= sel_d;
      pre_q         <= pre_d;
      shadow_tune_q <= shadow_tune_d;
      shadow_sel_q  <= shadow_sel_d;
      shadow_dur_q  <= shadow_dur_d;
    end
  end

  for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
    dds_note_timer #(
      .DurW(DUR_W)
    ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .load_i    (load[gi]),
      .load_val_i(shadow_dur_q[gi]),
      .gate_o    (gate_o[gi])
    );
  end

  assign wr_ready = ready_q;
  assign busy     = busy_q;
  assign tune_o   = tune_q;
  assign sel_o    = sel_q;

endmodule
